// File: rtl/rcu_adaptive.sv
// Registered route-compute unit for one input port of a 3D mesh router: Z-first, credit-adaptive
// X/Y, debounced UP/DOWN fault status with fixed backup ports, and a saturating DROP counter.
package rcu_pkg;
   localparam int COORD_W = 4;

   typedef struct packed {
      logic [COORD_W-1:0] z;
      logic [COORD_W-1:0] y;
      logic [COORD_W-1:0] x;
   } position_t;

   // EAST=+X, NORTH=+Y, UP=+Z
   typedef enum logic [2:0] {
      P_LOCAL = 3'd0,
      P_EAST  = 3'd1,
      P_WEST  = 3'd2,
      P_NORTH = 3'd3,
      P_SOUTH = 3'd4,
      P_UP    = 3'd5,
      P_DOWN  = 3'd6,
      P_DROP  = 3'd7
   } port_t;
endpackage

module rcu_adaptive
   import rcu_pkg::*;
#(
   parameter int        MESH_WIDTH    = 2,
   parameter int        MESH_HEIGHT   = 2,
   parameter int        MESH_DEPTH    = 2,
   parameter position_t THIS_POS      = '0,
   parameter bit        ADAPTIVE      = 1'b1,
   parameter int        CRED_W        = 3,
   parameter int        FAULT_PERSIST = 4,
   parameter int        DROP_CNT_W    = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  port_t                  in_inport_i,
   input  position_t              in_dest_i,
   input  logic                   up_fault_raw_i,
   input  logic                   dn_fault_raw_i,
   input  logic [3:0][CRED_W-1:0] credit_i,
   output logic                   route_valid_o,
   output port_t                  route_port_o,
   input  logic                   route_ack_i,
   input  logic                   pkt_done_i,
   output logic                   up_faulty_o,
   output logic                   dn_faulty_o,
   output logic [DROP_CNT_W-1:0]  drop_cnt_o
);
   localparam int XW = $clog2((MESH_WIDTH  > 2) ? MESH_WIDTH  : 2);
   localparam int YW = $clog2((MESH_HEIGHT > 2) ? MESH_HEIGHT : 2);
   localparam int ZW = $clog2((MESH_DEPTH  > 2) ? MESH_DEPTH  : 2);
   localparam int CW = $clog2(FAULT_PERSIST + 1);
   localparam logic [CW-1:0] PERSIST = CW'(FAULT_PERSIST);

   localparam bit ON_WEST  = (THIS_POS.x == '0);
   localparam bit ON_EAST  = (int'(THIS_POS.x) == MESH_WIDTH - 1);
   localparam bit ON_SOUTH = (THIS_POS.y == '0);
   localparam bit ON_NORTH = (int'(THIS_POS.y) == MESH_HEIGHT - 1);

   typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_OFFER, S_HOLD} state_t;

   state_t                  state_q, state_d;
   port_t                   port_q, port_d;
   logic [DROP_CNT_W-1:0]   drop_q, drop_d;
   logic [1:0]              faulty_q, faulty_d;
   logic [1:0][CW-1:0]      fcnt_q, fcnt_d;

   logic [XW-1:0]           dest_x_q;
   logic [YW-1:0]           dest_y_q;
   logic [ZW-1:0]           dest_z_q;
   port_t                   inport_q;

   logic [XW:0]             dx;
   logic [YW:0]             dy;
   logic [ZW:0]             dz;
   port_t                   backup, xport, yport, route_c;
   logic [CRED_W-1:0]       cred_x, cred_y;
   logic [1:0]              raw;
   logic                    unused_dest;

   // Coordinates wider than the mesh needs are deliberately ignored.
   assign unused_dest = ^in_dest_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dest_x_q <= '0;
         dest_y_q <= '0;
         dest_z_q <= '0;
         inport_q <= P_LOCAL;
      end else if (state_q == S_IDLE && in_valid_i) begin
         dest_x_q <= in_dest_i.x[XW-1:0];
         dest_y_q <= in_dest_i.y[YW-1:0];
         dest_z_q <= in_dest_i.z[ZW-1:0];
         inport_q <= in_inport_i;
      end
   end

   assign dx = {1'b0, dest_x_q} - {1'b0, THIS_POS.x[XW-1:0]};
   assign dy = {1'b0, dest_y_q} - {1'b0, THIS_POS.y[YW-1:0]};
   assign dz = {1'b0, dest_z_q} - {1'b0, THIS_POS.z[ZW-1:0]};

   // Backup output used when the productive Z link is faulty; depends only on arrival port.
   always_comb begin
      backup = P_EAST;
      case (inport_q)
         P_EAST: begin
            if (ON_WEST && MESH_HEIGHT == 1) backup = P_DROP;
            else if (ON_WEST && ON_NORTH)    backup = P_SOUTH;
            else if (ON_WEST)                backup = P_NORTH;
            else                             backup = P_WEST;
         end
         P_SOUTH: backup = ON_NORTH ? P_SOUTH : P_NORTH;
         P_NORTH: backup = ON_SOUTH ? P_DROP  : P_SOUTH;
         default: begin
            if (MESH_WIDTH == 1) begin
               if (MESH_HEIGHT == 1) backup = P_DROP;
               else if (ON_NORTH)    backup = P_SOUTH;
               else                  backup = P_NORTH;
            end else begin
               backup = ON_EAST ? P_WEST : P_EAST;
            end
         end
      endcase
   end

   always_comb begin
      xport  = dx[XW] ? P_WEST : P_EAST;
      yport  = dy[YW] ? P_SOUTH : P_NORTH;
      cred_x = dx[XW] ? credit_i[1] : credit_i[0];
      cred_y = dy[YW] ? credit_i[3] : credit_i[2];
      route_c = P_LOCAL;
      if (|dz) begin
         if (dz[ZW]) route_c = faulty_q[1] ? backup : P_DOWN;
         else        route_c = faulty_q[0] ? backup : P_UP;
      end else if ((|dx) && (|dy) && ADAPTIVE) begin
         route_c = (cred_y > cred_x) ? yport : xport;
      end else if (|dx) begin
         route_c = xport;
      end else if (|dy) begin
         route_c = yport;
      end
   end

   // Debounce: bit 0 is UP, bit 1 is DOWN.
   assign raw = {dn_fault_raw_i, up_fault_raw_i};

   always_comb begin
      faulty_d = faulty_q;
      fcnt_d   = fcnt_q;
      for (int i = 0; i < 2; i++) begin
         if (raw[i] == faulty_q[i]) begin
            fcnt_d[i] = '0;
         end else if (fcnt_q[i] + 1'b1 == PERSIST) begin
            faulty_d[i] = ~faulty_q[i];
            fcnt_d[i]   = '0;
         end else begin
            fcnt_d[i] = fcnt_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      port_d = (state_q == S_COMPUTE) ? route_c : port_q;
      drop_d = drop_q;
      if (state_q == S_OFFER && route_ack_i && port_q == P_DROP && drop_q != '1)
         drop_d = drop_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         port_q   <= P_LOCAL;
         drop_q   <= '0;
         faulty_q <= '0;
         fcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         port_q   <= port_d;
         drop_q   <= drop_d;
         faulty_q <= faulty_d;
         fcnt_q   <= fcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (in_valid_i)  state_d = S_COMPUTE;
         S_COMPUTE:                  state_d = S_OFFER;
         S_OFFER:   if (route_ack_i) state_d = S_HOLD;
         S_HOLD:    if (pkt_done_i)  state_d = S_IDLE;
         default:                    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready_o    = (state_q == S_IDLE);
      route_valid_o = (state_q == S_OFFER);
      route_port_o  = port_q;
      up_faulty_o   = faulty_q[0];
      dn_faulty_o   = faulty_q[1];
      drop_cnt_o    = drop_q;
   end

endmodule

// File: tb/tb_rcu_adaptive.sv
// Bench for rcu_adaptive: three 4x4x4 instances (adaptive, strict, corner router) driven in lockstep
// and compared against a route/debounce reference model computed from integer hop distances.
module tb_rcu_adaptive;
   import rcu_pkg::*;

   localparam int FP = 4;
   localparam int N  = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic            in_valid = 1'b0, up_raw = 1'b0, dn_raw = 1'b0;
   logic            route_ack = 1'b0, pkt_done = 1'b0;
   port_t           in_inport = P_LOCAL;
   position_t       in_dest = '0;
   logic [3:0][2:0] credit = '0;

   logic            rdy[3], rv[3], upf[3], dnf[3];
   port_t           rp[3];
   logic [7:0]      dc[3];

   int  tx[3]    = '{1, 1, 0};
   int  ty[3]    = '{1, 1, 0};
   int  tz[3]    = '{1, 1, 1};
   bit  adapt[3] = '{1'b1, 1'b0, 1'b1};

   int  checks = 0, failures = 0;
   bit  rand_faults = 1'b0;
   bit  mf[2];
   bit  hist[2][$];
   int  m_drop[3];

   rcu_adaptive #(.MESH_WIDTH(N), .MESH_HEIGHT(N), .MESH_DEPTH(N), .THIS_POS({4'd1, 4'd1, 4'd1}),
      .ADAPTIVE(1'b1), .CRED_W(3), .FAULT_PERSIST(FP), .DROP_CNT_W(8)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[0]), .in_inport_i(in_inport),
      .in_dest_i(in_dest), .up_fault_raw_i(up_raw), .dn_fault_raw_i(dn_raw), .credit_i(credit),
      .route_valid_o(rv[0]), .route_port_o(rp[0]), .route_ack_i(route_ack), .pkt_done_i(pkt_done),
      .up_faulty_o(upf[0]), .dn_faulty_o(dnf[0]), .drop_cnt_o(dc[0]));

   rcu_adaptive #(.MESH_WIDTH(N), .MESH_HEIGHT(N), .MESH_DEPTH(N), .THIS_POS({4'd1, 4'd1, 4'd1}),
      .ADAPTIVE(1'b0), .CRED_W(3), .FAULT_PERSIST(FP), .DROP_CNT_W(8)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[1]), .in_inport_i(in_inport),
      .in_dest_i(in_dest), .up_fault_raw_i(up_raw), .dn_fault_raw_i(dn_raw), .credit_i(credit),
      .route_valid_o(rv[1]), .route_port_o(rp[1]), .route_ack_i(route_ack), .pkt_done_i(pkt_done),
      .up_faulty_o(upf[1]), .dn_faulty_o(dnf[1]), .drop_cnt_o(dc[1]));

   rcu_adaptive #(.MESH_WIDTH(N), .MESH_HEIGHT(N), .MESH_DEPTH(N), .THIS_POS({4'd1, 4'd0, 4'd0}),
      .ADAPTIVE(1'b1), .CRED_W(3), .FAULT_PERSIST(FP), .DROP_CNT_W(8)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[2]), .in_inport_i(in_inport),
      .in_dest_i(in_dest), .up_fault_raw_i(up_raw), .dn_fault_raw_i(dn_raw), .credit_i(credit),
      .route_valid_o(rv[2]), .route_port_o(rp[2]), .route_ack_i(route_ack), .pkt_done_i(pkt_done),
      .up_faulty_o(upf[2]), .dn_faulty_o(dnf[2]), .drop_cnt_o(dc[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic position_t pos(input int x, input int y, input int z);
      position_t p;
      p.x = 4'(x);
      p.y = 4'(y);
      p.z = 4'(z);
      return p;
   endfunction

   // A fault flips once FP consecutive samples since the last flip all disagree with it.
   function automatic void fstep(input int i, input bit r);
      if (r == mf[i]) hist[i].delete();
      else begin
         hist[i].push_back(r);
         if (hist[i].size() == FP) begin
            mf[i] = !mf[i];
            hist[i].delete();
         end
      end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         mf[i] = 1'b0;
         hist[i].delete();
      end
      for (int k = 0; k < 3; k++) m_drop[k] = 0;
   endfunction

   function automatic int ref_route(input int k, input position_t d, input port_t ip,
                                    input logic [3:0][2:0] cr, input bit uf, input bit df);
      int dx, dy, dz, bk, xp, yp, cx, cy;
      bit north, south, east, west;
      dx = int'(d.x) - tx[k];
      dy = int'(d.y) - ty[k];
      dz = int'(d.z) - tz[k];
      north = (ty[k] == N - 1); south = (ty[k] == 0);
      east  = (tx[k] == N - 1); west  = (tx[k] == 0);
      if (ip == P_EAST)       bk = !west ? P_WEST : (N == 1 ? P_DROP : (north ? P_SOUTH : P_NORTH));
      else if (ip == P_SOUTH) bk = north ? P_SOUTH : P_NORTH;
      else if (ip == P_NORTH) bk = south ? P_DROP : P_SOUTH;
      else                    bk = east ? P_WEST : P_EAST;
      if (dz > 0) return uf ? bk : P_UP;
      if (dz < 0) return df ? bk : P_DOWN;
      xp = (dx > 0) ? P_EAST : P_WEST;
      yp = (dy > 0) ? P_NORTH : P_SOUTH;
      cx = (dx > 0) ? int'(cr[0]) : int'(cr[1]);
      cy = (dy > 0) ? int'(cr[2]) : int'(cr[3]);
      if (dx != 0 && dy != 0 && adapt[k]) return (cy > cx) ? yp : xp;
      if (dx != 0) return xp;
      if (dy != 0) return yp;
      return P_LOCAL;
   endfunction

   task automatic tick();
      bit u, d;
      u = up_raw;
      d = dn_raw;
      @(posedge clk);
      if (rst_n) begin
         fstep(0, u);
         fstep(1, d);
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("up_faulty", upf[k], mf[0]);
         chk("dn_faulty", dnf[k], mf[1]);
      end
      if (rand_faults) begin
         if ($urandom_range(5) == 0) up_raw = ~up_raw;
         if ($urandom_range(5) == 0) dn_raw = ~dn_raw;
      end
   endtask

   // want* < 0 means rely on the model alone for that instance.
   task automatic do_pkt(input position_t d, input port_t ip, input logic [3:0][2:0] cr,
                         input int ack_wait, input int done_wait,
                         input int want0, input int want1, input int want2);
      int exp[3];
      int want[3];
      want = '{want0, want1, want2};
      for (int k = 0; k < 3; k++) begin
         chk("idle_ready", rdy[k], 1);
         chk("idle_valid", rv[k], 0);
      end
      in_valid = 1'b1; in_dest = d; in_inport = ip; credit = cr;
      tick();
      in_valid = 1'b0;
      in_dest = position_t'(12'($urandom));
      in_inport = port_t'(3'($urandom_range(7)));
      for (int k = 0; k < 3; k++) begin
         exp[k] = ref_route(k, d, ip, cr, mf[0], mf[1]);
         chk("compute_ready", rdy[k], 0);
         chk("compute_valid", rv[k], 0);
      end
      tick();
      credit = 12'($urandom);
      for (int w = 0; w <= ack_wait; w++) begin
         for (int k = 0; k < 3; k++) begin
            chk("offer_valid", rv[k], 1);
            chk("offer_ready", rdy[k], 0);
            chk("offer_port", rp[k], exp[k]);
            if (want[k] >= 0) chk("directed_port", rp[k], want[k]);
         end
         if (w == ack_wait) break;
         pkt_done = 1'b1;
         tick();
         pkt_done = 1'b0;
      end
      route_ack = 1'b1;
      tick();
      route_ack = 1'b0;
      for (int k = 0; k < 3; k++)
         if (exp[k] == P_DROP && m_drop[k] < 255) m_drop[k]++;
      for (int w = 0; w < done_wait; w++) begin
         for (int k = 0; k < 3; k++) begin
            chk("hold_valid", rv[k], 0);
            chk("hold_ready", rdy[k], 0);
            chk("hold_port", rp[k], exp[k]);
            chk("hold_drop", dc[k], m_drop[k]);
         end
         route_ack = 1'b1;
         tick();
         route_ack = 1'b0;
      end
      pkt_done = 1'b1;
      tick();
      pkt_done = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("release_ready", rdy[k], 1);
         chk("drop_cnt", dc[k], m_drop[k]);
      end
   endtask

   initial begin
      model_reset();
      // Reset state
      tick();
      tick();
      for (int k = 0; k < 3; k++) begin
         chk("rst_ready", rdy[k], 1);
         chk("rst_valid", rv[k], 0);
         chk("rst_port", rp[k], P_LOCAL);
         chk("rst_drop", dc[k], 0);
      end
      rst_n = 1'b1;
      tick();

      // Z first: straight up
      do_pkt(pos(1, 1, 3), P_LOCAL, {3'd3, 3'd3, 3'd3, 3'd3}, 0, 2, P_UP, P_UP, -1);

      // Debounce: 3 samples are not enough, 4 are
      up_raw = 1'b1;
      repeat (3) tick();
      up_raw = 1'b0;
      tick();
      chk("up_short_glitch", upf[0], 0);
      up_raw = 1'b1;
      repeat (4) tick();
      chk("up_persist", upf[0], 1);
      do_pkt(pos(1, 1, 3), P_LOCAL, {3'd3, 3'd3, 3'd3, 3'd3}, 0, 1, P_EAST, P_EAST, P_EAST);
      up_raw = 1'b0;
      repeat (4) tick();
      chk("up_cleared", upf[0], 0);

      // Adaptive X/Y by credits; credit order {S, N, W, E}
      do_pkt(pos(3, 3, 1), P_LOCAL, {3'd0, 3'd5, 3'd0, 3'd1}, 0, 1, P_NORTH, P_EAST, -1);
      do_pkt(pos(3, 3, 1), P_LOCAL, {3'd0, 3'd2, 3'd0, 3'd2}, 0, 1, P_EAST, P_EAST, -1);
      do_pkt(pos(0, 0, 1), P_WEST, {3'd6, 3'd0, 3'd1, 3'd0}, 1, 1, P_SOUTH, P_WEST, P_LOCAL);

      // Local delivery with a stalled allocator
      do_pkt(pos(1, 1, 1), P_EAST, {3'd1, 3'd1, 3'd1, 3'd1}, 5, 2, P_LOCAL, P_LOCAL, -1);

      // DOWN faulty at the south-west corner router from NORTH: dropped, then saturate
      dn_raw = 1'b1;
      repeat (4) tick();
      chk("dn_persist", dnf[2], 1);
      do_pkt(pos(0, 0, 0), P_NORTH, {3'd1, 3'd1, 3'd1, 3'd1}, 0, 1, P_SOUTH, P_SOUTH, P_DROP);
      chk("drop_first", dc[2], 1);
      for (int i = 0; i < 258; i++)
         do_pkt(pos(0, 0, 0), P_NORTH, 12'($urandom), 0, 0, -1, -1, P_DROP);
      chk("drop_saturated", dc[2], 255);
      chk("drop_other", dc[0], 0);
      dn_raw = 1'b0;

      // Reset in HOLD
      in_valid = 1'b1; in_dest = pos(3, 1, 1); in_inport = P_LOCAL;
      tick();
      in_valid = 1'b0;
      tick();
      route_ack = 1'b1;
      tick();
      route_ack = 1'b0;
      chk("pre_rst_hold_ready", rdy[0], 0);
      rst_n = 1'b0;
      #1;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         chk("midrst_valid", rv[k], 0);
         chk("midrst_ready", rdy[k], 1);
         chk("midrst_drop", dc[k], 0);
         chk("midrst_port", rp[k], P_LOCAL);
         chk("midrst_dnf", dnf[k], 0);
      end
      tick();
      rst_n = 1'b1;
      pkt_done = 1'b1;
      tick();
      pkt_done = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("post_rst_ready", rdy[k], 1);
         chk("post_rst_valid", rv[k], 0);
      end

      // Randomised traffic with wandering fault inputs
      rand_faults = 1'b1;
      for (int i = 0; i < 200; i++)
         do_pkt(pos($urandom_range(N - 1), $urandom_range(N - 1), $urandom_range(N - 1)),
                port_t'(3'($urandom_range(6))), 12'($urandom),
                $urandom_range(3), $urandom_range(3), -1, -1, -1);
      rand_faults = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
